// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I widths, memory geometry, LSU operation/state types and op-class helpers
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int MEM_SIZE = 1024;
    localparam int AW = $clog2(MEM_SIZE);
    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LH  = 4'd2,
        OP_LW  = 4'd3,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } operation_e;
    typedef enum logic [2:0] {S_IDLE, S_FIRST, S_SECOND, S_WAIT, S_RESP} lsu_state_e;
    function automatic logic is_load(operation_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction
    function automatic logic is_store(operation_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction
    function automatic logic is_split(operation_e op, logic [1:0] off);
        return (op inside {OP_LH, OP_LHU, OP_SH} && off == 2'd3) || (op inside {OP_LW, OP_SW} && off != 2'd0);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane shift/byte-mask (64-bit span) and load shift/extend from {hi,lo} words
module lsu_lane_align
    import riscv_pkg::*;
(
    input  operation_e  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [63:0] st_data,
    output logic [7:0]  st_mask,
    output logic [31:0] ld_data
);
    logic [31:0] s;
    always_comb begin
        st_data = {32'b0, wdata} << {off, 3'b000};
        st_mask = (op == OP_SB ? 8'h01 : op == OP_SH ? 8'h03 : 8'h0F) << off;
        s = 32'({hi, lo} >> {off, 3'b000});
        ld_data = op == OP_LB  ? {{24{s[7]}}, s[7:0]} :
                  op == OP_LH  ? {{16{s[15]}}, s[15:0]} :
                  op == OP_LBU ? {24'b0, s[7:0]} :
                  op == OP_LHU ? {16'b0, s[15:0]} : s;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed RV32I load/store to word memory, splitting word-crossing accesses in two
module load_store_unit
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  operation_e      operation_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      rf_addr_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_data_o,
    output logic [4:0]      rsp_rf_addr_o,
    output logic            rsp_rf_we_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    input  logic [31:0]     mem_rdata_i
);
    lsu_state_e    state;
    operation_e    op_q;
    logic [1:0]    off_q;
    logic [AW-1:0] word_q;
    logic [31:0]   wdata_q, lo_q, lo_in, hi_in, ld_data;
    logic [4:0]    rf_q;
    logic          split_q, second;
    logic [63:0]   st_data;
    logic [7:0]    st_mask;
    lsu_lane_align u_align (
        .op      (op_q),
        .off     (off_q),
        .wdata   (wdata_q),
        .lo      (lo_in),
        .hi      (hi_in),
        .st_data (st_data),
        .st_mask (st_mask),
        .ld_data (ld_data)
    );
    always_comb begin
        second = state == S_SECOND;
        req_ready_o = state == S_IDLE;
        rsp_valid_o = state == S_RESP;
        mem_req_o = (state == S_FIRST || second) && !rst_i;
        mem_we_o = mem_req_o && is_store(op_q);
        mem_be_o = !mem_req_o ? 4'h0 : !mem_we_o ? 4'hF : second ? st_mask[7:4] : st_mask[3:0];
        mem_addr_o = !mem_req_o ? '0 : second ? word_q + AW'(1) : word_q;
        mem_wdata_o = !mem_we_o ? '0 : second ? st_data[63:32] : st_data[31:0];
        lo_in = split_q ? lo_q : mem_rdata_i;
        hi_in = split_q ? mem_rdata_i : '0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            op_q <= OP_NOP;
            off_q <= '0;
            word_q <= '0;
            wdata_q <= '0;
            lo_q <= '0;
            rf_q <= '0;
            split_q <= 1'b0;
            rsp_data_o <= '0;
            rsp_rf_addr_o <= '0;
            rsp_rf_we_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid_i) begin
                    op_q <= operation_i;
                    off_q <= addr_i[1:0];
                    word_q <= addr_i[AW+1:2];
                    wdata_q <= wdata_i;
                    rf_q <= rf_addr_i;
                    split_q <= is_split(operation_i, addr_i[1:0]);
                    if (is_load(operation_i) || is_store(operation_i)) begin
                        state <= S_FIRST;
                    end else begin
                        state <= S_RESP;
                        rsp_data_o <= '0;
                        rsp_rf_addr_o <= rf_addr_i;
                        rsp_rf_we_o <= 1'b0;
                    end
                end
                S_FIRST, S_SECOND: begin
                    if (second) lo_q <= mem_rdata_i;
                    if (state == S_FIRST && split_q) begin
                        state <= S_SECOND;
                    end else if (is_load(op_q)) begin
                        state <= S_WAIT;
                    end else begin
                        state <= S_RESP;
                        rsp_data_o <= '0;
                        rsp_rf_addr_o <= rf_q;
                        rsp_rf_we_o <= 1'b0;
                    end
                end
                S_WAIT: begin
                    state <= S_RESP;
                    rsp_data_o <= ld_data;
                    rsp_rf_addr_o <= rf_q;
                    rsp_rf_we_o <= rf_q != 5'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side load/store unit between the execute stage and the word-organised data memory (MEM_SIZE × 32-bit, synchronous read). Accepts one byte-addressed RV32I load/store per request, generates word address, byte enables and lane-shifted write data, and splits any access that crosses a word boundary into two word accesses. Loads are reassembled and sign- or zero-extended, then returned with register-file write-back info.

## Interface
- XLEN, 32 (riscv_pkg): data and address width.
- MEM_SIZE, 1024 (riscv_pkg): data memory depth in 32-bit words; word address width AW = $clog2(MEM_SIZE).
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request from execute is valid.
- req_ready_o  out  1  unit can accept; request accepted when req_valid_i && req_ready_o.
- operation_i  in  operation_e  LB/LH/LW/LBU/LHU/SB/SH/SW; any other value is a no-op.
- addr_i  in  XLEN  byte address.
- wdata_i  in  XLEN  store data, right-aligned.
- rf_addr_i  in  5  destination register.
- rsp_valid_o  out  1  one-cycle completion pulse, every accepted request.
- rsp_data_o  out  XLEN  extended load data; 0 for stores and no-ops.
- rsp_rf_addr_o  out  5  destination register of completed request.
- rsp_rf_we_o  out  1  1 only for loads with rf_addr ≠ 0.
- mem_req_o  out  1  memory access this cycle.
- mem_we_o  out  1  write access.
- mem_be_o  out  4  byte enables (writes); 4'hF on reads.
- mem_addr_o  out  AW  word address.
- mem_wdata_o  out  32  lane-shifted write data.
- mem_rdata_i  in  32  read data, valid the cycle after a read mem_req_o.

## Operation
- Request fields latched on acceptance; off = addr[1:0], word = addr[AW+1:2].
- split = (LH/LHU/SH and off==3) or (LW/SW and off≠0). Byte ops never split.
- Stores: 64-bit data {32'b0,wdata} << 8·off; 8-bit mask (1/3/F for B/H/W) << off. First access uses lower halves at word; second uses upper halves at (word+1) mod MEM_SIZE.
- Loads: {hi,lo} >> 8·off (hi = 0 if not split), low 8/16/32 bits taken, bit 7/15 replicated for LB/LH, zero-filled for LBU/LHU.
- FSM states IDLE, FIRST, SECOND, WAIT, RESP:
  - IDLE: req_ready_o=1; accept → FIRST (no-op → RESP).
  - FIRST: access at word; split → SECOND; else load → WAIT, store → RESP.
  - SECOND: access at word+1; captures lo read data; load → WAIT, store → RESP.
  - WAIT: captures last read data, computes rsp_data → RESP.
  - RESP: rsp_valid_o=1 → IDLE.
- req_ready_o=0 outside IDLE; upstream holds the request; no back-to-back acceptance.

## Timing
- Reset: state IDLE; req_ready_o=1 from first post-reset cycle; rsp_valid_o, rsp_data_o, rsp_rf_addr_o, rsp_rf_we_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o all 0.
- Accept in cycle T: aligned load rsp at T+3, split load T+4, aligned store T+2, split store T+3, no-op T+1.
- mem_* outputs are decoded from state and latched fields; no memory access in IDLE, WAIT, RESP.
- rsp_* fields hold value until next RESP.
- Reset asserted mid-operation: next cycle IDLE, outputs as reset; a split store may leave only its first word written (no rollback).
- Word wrap: split at last word (word = MEM_SIZE-1) continues at word 0.

## Structure
- riscv_pkg: XLEN, MEM_SIZE, operation_e (existing); add lsu_state_e and functions is_load(op), is_store(op).
- Sub-module lsu_lane_align (combinational): store lane shift/byte-enable and load shift/extend, so both directions are unit-testable.

## Test plan
- Reset with req_valid_i=1 → all outputs 0, req_ready_o=1 after release; no mem_req_o.
- SW 0xDEADBEEF @0x10, then LW @0x10 → one write word 4 be F; rsp_data 0xDEADBEEF at T+3, rsp_rf_we=1.
- SB 0x80 @0x21, then LB and LBU @0x21 → be 4'b0010, wdata 0x00008000; LB 0xFFFFFF80, LBU 0x00000080.
- SW 0x11223344 @0x0E (split) → word 3 be C data 0x33440000, then word 4 be 3 data 0x00001122; LW @0x0E returns 0x11223344 at T+4.
- LH @ byte 4·MEM_SIZE-1 with word MEM_SIZE-1 = 0xAB000000, word 0 = 0x000000CD → reads MEM_SIZE-1 then 0; rsp 0xFFFFCDAB.
- LW to x0 → rsp_rf_we=0; unknown op → rsp at T+1, no mem_req_o; rst_i in SECOND of split store → only first word written, IDLE next cycle.
